// File: rtl/mem_responder.sv
// mem_responder: target end of the multi-cycle CPU's unified memory port.
// Accepts one 32-bit word read or write per request. It holds the access for
// WAIT_CYCLES wait states, then answers with a one-cycle ready pulse. err is
// raised with ready for a misaligned or out-of-range access.
//
// Ports
//   clk     rising-edge clock
//   rstn    synchronous active-low reset (control state and counters only)
//   req     access request, held by the requester until ready
//   we      1 = write, 0 = read
//   addr    byte address
//   wdata   write data
//   rdata   read data, non-zero only in a good read response
//   ready   one-cycle completion pulse
//   err     illegal access, asserted together with ready
//   busy    high while an access is in progress
//   rd_cnt  completed good reads, saturating
//   wr_cnt  completed good writes, saturating
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  logic [31:0] mem [DEPTH];

  logic                  illegal;
  logic                  good_rd;
  logic                  good_wr;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] widx;

  assign accept  = (state == IDLE) && req;
  assign widx    = addr_q[DEPTH_LOG2+1:2];
  // Any address bit above the array's byte range makes the access illegal.
  assign illegal = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign good_rd = (state == RESP) && !illegal && !we_q;
  assign good_wr = (state == RESP) && !illegal && we_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        // cnt==1 is the last wait state; <= also covers a stray zero.
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (good_rd && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (good_wr && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  // Request capture: the access is frozen at the accept edge, so later
  // changes on addr/we/wdata do not disturb it.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      we_q    <= we;
      wdata_q <= wdata;
    end
  end

  // The array commits on the edge that ends RESP; a reset on that edge
  // abandons the write.
  always_ff @(posedge clk) begin
    if (rstn && good_wr) begin
      mem[widx] <= wdata_q;
    end
  end

  assign ready  = (state == RESP);
  assign err    = (state == RESP) && illegal;
  assign busy   = (state != IDLE);
  assign rdata  = good_rd ? mem[widx] : 32'd0;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance a uses one wait state, instance b uses
// zero wait states for the back-to-back case. A forked monitor pops expected
// responses from per-instance queues whenever ready is seen.
module tb_mem_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  localparam int WA = 1;
  localparam int WB = 0;

  logic        clk;
  logic        rstn;

  logic        req_a, we_a, ready_a, err_a, busy_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic [15:0] rd_cnt_a, wr_cnt_a;

  logic        req_b, we_b, ready_b, err_b, busy_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [15:0] rd_cnt_b, wr_cnt_b;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int n_vec;
  int n_fail;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .rstn(rstn), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a),
    .busy(busy_a), .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .rstn(rstn), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b),
    .busy(busy_b), .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready_a) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = exp_a.pop_front();
          chk("a_err", {31'd0, err_a}, {31'd0, e.err});
          chk("a_rdata", rdata_a, e.rd);
        end
      end
      if (ready_b) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = exp_b.pop_front();
          chk("b_err", {31'd0, err_b}, {31'd0, e.err});
          chk("b_rdata", rdata_b, e.rd);
        end
      end
    end
  endtask

  // One access on instance a; optionally scrambles addr/wdata after accept.
  task automatic acc_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic xerr, input logic [31:0] xrd, input bit scramble);
    int n;
    bit got;
    exp_a.push_back('{err: xerr, rd: xrd});
    @(negedge clk);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (scramble && i == 1) begin
        addr_a = a + 32'd4;
        wdata_a = 32'd0;
      end
      if (ready_a) begin
        got = 1'b1;
        n = i;
      end
    end
    chk("a_latency", n, WA + 1);
    req_a = 1'b0;
  endtask

  initial begin
    logic        op_we [4];
    logic [31:0] op_ad [4];
    logic [31:0] op_wd [4];
    logic [31:0] op_rd [4];
    int k, last, low;

    n_vec = 0;
    n_fail = 0;
    rstn = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
    req_b = 1'b0; we_b = 1'b0; addr_b = 32'd0; wdata_b = 32'd0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_rd_cnt", {16'd0, rd_cnt_a}, 32'd0);
    chk("rst_wr_cnt", {16'd0, wr_cnt_a}, 32'd0);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    rstn = 1'b1;

    // Back-to-back on the zero-wait instance with req held high.
    op_we[0] = 1'b1; op_ad[0] = 32'h0; op_wd[0] = 32'hCAFE0001; op_rd[0] = 32'h0;
    op_we[1] = 1'b1; op_ad[1] = 32'h4; op_wd[1] = 32'hCAFE0002; op_rd[1] = 32'h0;
    op_we[2] = 1'b0; op_ad[2] = 32'h0; op_wd[2] = 32'h0;        op_rd[2] = 32'hCAFE0001;
    op_we[3] = 1'b0; op_ad[3] = 32'h4; op_wd[3] = 32'h0;        op_rd[3] = 32'hCAFE0002;
    @(negedge clk);
    exp_b.push_back('{err: 1'b0, rd: op_rd[0]});
    req_b = 1'b1; we_b = op_we[0]; addr_b = op_ad[0]; wdata_b = op_wd[0];
    k = 0; last = -1; low = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(negedge clk);
      if (ready_b) begin
        if (k > 0) begin
          chk("b2b_period", cyc - last, 2);
          chk("b2b_busy_low", low, 1);
        end
        last = cyc;
        low = 0;
        k++;
        if (k < 4) begin
          exp_b.push_back('{err: 1'b0, rd: op_rd[k]});
          we_b = op_we[k]; addr_b = op_ad[k]; wdata_b = op_wd[k];
        end else begin
          req_b = 1'b0;
        end
      end else if (!busy_b) begin
        low++;
      end
    end
    chk("b2b_done", k, 4);
    req_b = 1'b0;
    @(negedge clk);
    chk("b_wr_cnt", {16'd0, wr_cnt_b}, 32'd2);
    chk("b_rd_cnt", {16'd0, rd_cnt_b}, 32'd2);

    // Write then read back with one wait state.
    acc_a(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("t1_wr_cnt", {16'd0, wr_cnt_a}, 32'd1);
    acc_a(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("t1_rd_cnt", {16'd0, rd_cnt_a}, 32'd1);

    // Illegal accesses: misaligned and out of range.
    acc_a(1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0);
    acc_a(1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b0);
    acc_a(1'b1, 32'h401, 32'h55555555, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("t3_rd_cnt", {16'd0, rd_cnt_a}, 32'd1);
    chk("t3_wr_cnt", {16'd0, wr_cnt_a}, 32'd1);

    // Inputs changed while busy must not affect the access.
    acc_a(1'b1, 32'h24, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    acc_a(1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b1);
    acc_a(1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 1'b0);
    acc_a(1'b0, 32'h24, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    chk("t4_wr_cnt", {16'd0, wr_cnt_a}, 32'd3);
    chk("t4_rd_cnt", {16'd0, rd_cnt_a}, 32'd3);

    // Reset during the wait state of a write abandons it.
    acc_a(1'b1, 32'h30, 32'h11112222, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h30; wdata_a = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy_wait", {31'd0, busy_a}, 32'd1);
    rstn = 1'b0;
    req_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ready", {31'd0, ready_a}, 32'd0);
    chk("t5_err", {31'd0, err_a}, 32'd0);
    chk("t5_busy", {31'd0, busy_a}, 32'd0);
    chk("t5_rd_cnt", {16'd0, rd_cnt_a}, 32'd0);
    chk("t5_wr_cnt", {16'd0, wr_cnt_a}, 32'd0);
    rstn = 1'b1;
    acc_a(1'b0, 32'h30, 32'h0, 1'b0, 32'h11112222, 1'b0);
    @(negedge clk);
    chk("t5_rd_after", {16'd0, rd_cnt_a}, 32'd1);

    // Read counter saturation.
    force dut_a.rd_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.rd_cnt_q;
    @(negedge clk);
    chk("t6_preload", {16'd0, rd_cnt_a}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      acc_a(1'b0, 32'h30, 32'h0, 1'b0, 32'h11112222, 1'b0);
      @(negedge clk);
      chk("t6_rd_sat", {16'd0, rd_cnt_a}, 32'h0000FFFF);
    end

    repeat (2) @(negedge clk);
    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
